// File: rtl/margin_topk_stream_if.sv
// Score-vector stream bundle for margin_topk_stream: valid/ready handshake,
// packed class scores and end-of-run marker.
interface margin_topk_stream_if #(
  parameter int NUM_CLASSES = 4,
  parameter int SCORE_W     = 16
);
  logic                           in_valid;
  logic                           in_ready;
  logic                           in_last;
  logic [NUM_CLASSES*SCORE_W-1:0] in_scores;

  modport master (output in_valid, in_scores, in_last, input in_ready);
  modport slave  (input in_valid, in_scores, in_last, output in_ready);
endinterface

// File: rtl/margin_topk_stream.sv
// Streaming margin selector: keeps the K samples with the smallest top1-top2 key.
// Optional feature: `MARGIN_LC_MODE_EN enables the least-confidence key (top1) via mode_i.
module margin_topk_stream #(
  parameter int NUM_CLASSES = 4,
  parameter int SCORE_W     = 16,
  parameter int K           = 10,
  parameter int IDX_W       = 16,
  localparam int CW = $clog2(K + 1),
  localparam int AW = (K > 1) ? $clog2(K) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    mode_i,
  margin_topk_stream_if.slave     in_if,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [CW-1:0]           count_o,
  input  logic [AW-1:0]           rd_addr_i,
  output logic [IDX_W-1:0]        rd_idx_o,
  output logic [SCORE_W-1:0]      rd_key_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e state_q, state_d;
  logic   drain_q, drain_d;
  logic   ready, clear, accept;

  logic                           s1_valid_q;
  logic [NUM_CLASSES*SCORE_W-1:0] s1_scores_q;
  logic [IDX_W-1:0]               s1_idx_q;
  logic                           s2_valid_q;
  logic [SCORE_W-1:0]             s2_key_q;
  logic [IDX_W-1:0]               s2_idx_q;
  logic [IDX_W-1:0]               sample_q;

  logic [SCORE_W-1:0] key_q [K];
  logic [IDX_W-1:0]   idx_q [K];
  logic [SCORE_W-1:0] key_d [K];
  logic [IDX_W-1:0]   idx_d [K];
  logic [CW-1:0]      count_q, count_d;
  logic               ins;

  logic [SCORE_W-1:0] top1, top2, sc, key_new;
  int unsigned        pos;

  assign accept         = in_if.in_valid && ready;
  assign in_if.in_ready = ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN: begin
        if (accept && in_if.in_last) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end
      end
      S_DRAIN: begin
        if (drain_q) state_d = S_DONE;
        else         drain_d = 1'b1;
      end
      S_DONE:  if (start_i) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ready  = (state_q == S_RUN);
    busy_o = (state_q == S_RUN) || (state_q == S_DRAIN);
    done_o = (state_q == S_DONE);
    clear  = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  end

`ifdef MARGIN_LC_MODE_EN
  logic mode_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        mode_q <= 1'b0;
    else if (clear) mode_q <= mode_i;
  end
`else
  logic mode_unused;
  assign mode_unused = mode_i;
`endif

  // Stage 1 works on registered scores; a later equal score is taken as top2
  always_comb begin
    top1 = '0;
    top2 = '0;
    sc   = '0;
    for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
      sc = s1_scores_q[c*SCORE_W +: SCORE_W];
      if (sc > top1) begin
        top2 = top1;
        top1 = sc;
      end else if (sc > top2) begin
        top2 = sc;
      end
    end
`ifdef MARGIN_LC_MODE_EN
    key_new = mode_q ? top1 : (top1 - top2);
`else
    key_new = top1 - top2;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_scores_q <= '0;
      s1_idx_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_key_q    <= '0;
      s2_idx_q    <= '0;
      sample_q    <= '0;
    end else if (clear) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      sample_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_scores_q <= in_if.in_scores;
        s1_idx_q    <= sample_q;
        sample_q    <= sample_q + 1'b1;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_key_q <= key_new;
        s2_idx_q <= s1_idx_q;
      end
    end
  end

  // Insertion: valid keys <= new key form a prefix, so pos splits keep/shift
  always_comb begin
    pos = 0;
    for (int unsigned i = 0; i < K; i++)
      if (i < 32'(count_q) && key_q[i] <= s2_key_q) pos = pos + 1;
    ins = s2_valid_q && (pos < K);
    for (int unsigned i = 0; i < K; i++) begin
      key_d[i] = key_q[i];
      idx_d[i] = idx_q[i];
      if (i == pos) begin
        key_d[i] = s2_key_q;
        idx_d[i] = s2_idx_q;
      end else if (i > pos) begin
        key_d[i] = key_q[i-1];
        idx_d[i] = idx_q[i-1];
      end
    end
    count_d = count_q;
    if (ins && count_q != CW'(K)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      for (int unsigned i = 0; i < K; i++) begin
        key_q[i] <= '1;
        idx_q[i] <= '1;
      end
    end else if (clear) begin
      count_q <= '0;
      for (int unsigned i = 0; i < K; i++) begin
        key_q[i] <= '1;
        idx_q[i] <= '1;
      end
    end else if (ins) begin
      count_q <= count_d;
      for (int unsigned i = 0; i < K; i++) begin
        key_q[i] <= key_d[i];
        idx_q[i] <= idx_d[i];
      end
    end
  end

  assign count_o = count_q;

  always_comb begin
    rd_idx_o = '1;
    rd_key_o = '1;
    if (32'(rd_addr_i) < K) begin
      rd_idx_o = idx_q[rd_addr_i];
      rd_key_o = key_q[rd_addr_i];
    end
  end

endmodule

// File: tb/tb_margin_topk_stream.sv
// Directed self-checking bench for margin_topk_stream (default and IDX_W=4 instances).
module tb_margin_topk_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0, mode = 1'b0, busy, done;
  logic [3:0]  count, rd_addr = '0;
  logic [15:0] rd_idx, rd_key;

  logic        start_w = 1'b0, busy_w, done_w;
  logic [3:0]  count_w, rd_addr_w = '0;
  logic [3:0]  rd_idx_w;
  logic [15:0] rd_key_w;

  margin_topk_stream_if #(.NUM_CLASSES(4), .SCORE_W(16)) bus ();
  margin_topk_stream_if #(.NUM_CLASSES(4), .SCORE_W(16)) bus_w ();

  margin_topk_stream #(.NUM_CLASSES(4), .SCORE_W(16), .K(10), .IDX_W(16)) dut (
    .clk(clk), .rst(rst), .start_i(start), .mode_i(mode), .in_if(bus.slave),
    .busy_o(busy), .done_o(done), .count_o(count), .rd_addr_i(rd_addr),
    .rd_idx_o(rd_idx), .rd_key_o(rd_key));

  margin_topk_stream #(.NUM_CLASSES(4), .SCORE_W(16), .K(10), .IDX_W(4)) dut_w (
    .clk(clk), .rst(rst), .start_i(start_w), .mode_i(1'b0), .in_if(bus_w.slave),
    .busy_o(busy_w), .done_o(done_w), .count_o(count_w), .rd_addr_i(rd_addr_w),
    .rd_idx_o(rd_idx_w), .rd_key_o(rd_key_w));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] v4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic push(input logic [63:0] s, input logic last);
    bus.in_valid  = 1'b1;
    bus.in_scores = s;
    bus.in_last   = last;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic push_w(input logic [63:0] s, input logic last);
    bus_w.in_valid  = 1'b1;
    bus_w.in_scores = s;
    bus_w.in_last   = last;
    @(negedge clk);
    bus_w.in_valid = 1'b0;
    bus_w.in_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", 32'(done), 1);
  endtask

  task automatic rd(input string tag, input int addr, input logic [15:0] ei, input logic [15:0] ek);
    rd_addr = 4'(addr);
    #1;
    check({tag, "_idx"}, 32'(rd_idx), 32'(ei));
    check({tag, "_key"}, 32'(rd_key), 32'(ek));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_scores = '0;
    bus_w.in_valid = 1'b0; bus_w.in_last = 1'b0; bus_w.in_scores = '0;
    @(negedge clk); @(negedge clk);
    check("rst_ready", 32'(bus.in_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_count", 32'(count), 0);
    rd("rst_slot0", 0, 16'hFFFF, 16'hFFFF);
    rst = 1'b0;
    @(negedge clk);

    // Reset mid-run with data in flight
    pulse_start();
    check("run_ready", 32'(bus.in_ready), 1);
    push(v4(1, 2, 3, 4), 1'b0);
    push(v4(9, 2, 3, 4), 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'(bus.in_ready), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_count", 32'(count), 0);
    rd("midrst_slot0", 0, 16'hFFFF, 16'hFFFF);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    push(v4(3, 9, 0, 0), 1'b1);
    wait_done(10);
    check("single_count", 32'(count), 1);
    rd("single_slot0", 0, 16'd0, 16'd6);
    rd("single_slot1", 1, 16'hFFFF, 16'hFFFF);

    // Start from DONE clears the list on the same edge
    pulse_start();
    check("restart_done", 32'(done), 0);
    check("restart_busy", 32'(busy), 1);
    check("restart_count", 32'(count), 0);
    rd("restart_slot0", 0, 16'hFFFF, 16'hFFFF);

    // Basic run with exact pipeline timing
    push(v4(140, 197, 200, 0), 1'b0);
    push(v4(14, 200, 200, 0), 1'b0);
    push(v4(15, 158, 210, 0), 1'b1);
    check("basic_cnt_e2", 32'(count), 1);
    check("basic_done_e2", 32'(done), 0);
    check("basic_ready_drain", 32'(bus.in_ready), 0);
    @(negedge clk);
    check("basic_cnt_e3", 32'(count), 2);
    check("basic_done_e3", 32'(done), 0);
    @(negedge clk);
    check("basic_cnt_e4", 32'(count), 3);
    check("basic_done_e4", 32'(done), 1);
    check("basic_busy_done", 32'(busy), 0);
    rd("basic_s0", 0, 16'd1, 16'd0);
    rd("basic_s1", 1, 16'd0, 16'd3);
    rd("basic_s2", 2, 16'd2, 16'd52);
    for (int a = 3; a < 10; a++) rd("basic_empty", a, 16'hFFFF, 16'hFFFF);
    rd("basic_oob", 15, 16'hFFFF, 16'hFFFF);

    // Eviction: margins 11..0
    pulse_start();
    for (int i = 0; i < 12; i++) push(v4(50, 100 - (11 - i), 100, 0), i == 11);
    wait_done(10);
    check("evict_count", 32'(count), 10);
    for (int j = 0; j < 10; j++) rd("evict", j, 16'(11 - j), 16'(j));

    // Ties with gaps and an ignored mid-run start
    pulse_start();
    for (int i = 0; i < 15; i++) begin
      if (i == 7) start = 1'b1;
      push(v4(50, 45, 0, 0), i == 14);
      start = 1'b0;
      if (i == 7) begin
        check("ties_start_busy", 32'(busy), 1);
        check("ties_start_ready", 32'(bus.in_ready), 1);
      end
      if (i % 3 == 1) @(negedge clk);
      if (i % 4 == 2) begin @(negedge clk); @(negedge clk); end
    end
    wait_done(10);
    check("ties_count", 32'(count), 10);
    for (int j = 0; j < 10; j++) rd("ties", j, 16'(j), 16'd5);

    // Mode held from the start cycle
    mode = 1'b1;
    pulse_start();
    mode = 1'b0;
    push(v4(10, 15, 3, 0), 1'b0);
    push(v4(100, 94, 59, 58), 1'b0);
    push(v4(1, 10, 100, 110), 1'b1);
    wait_done(10);
    check("mode_count", 32'(count), 3);
`ifdef MARGIN_LC_MODE_EN
    rd("mode_s0", 0, 16'd0, 16'd15);
    rd("mode_s1", 1, 16'd1, 16'd100);
    rd("mode_s2", 2, 16'd2, 16'd110);
`else
    rd("mode_s0", 0, 16'd0, 16'd5);
    rd("mode_s1", 1, 16'd1, 16'd6);
    rd("mode_s2", 2, 16'd2, 16'd10);
`endif

    // Index wrap on the IDX_W=4 instance
    start_w = 1'b1;
    @(negedge clk);
    start_w = 1'b0;
    for (int i = 0; i < 20; i++) push_w((i == 17) ? v4(30, 29, 0, 0) : v4(30, 23, 0, 0), i == 19);
    begin
      int n = 0;
      while (!done_w && n < 10) begin @(negedge clk); n++; end
    end
    check("wrap_done", 32'(done_w), 1);
    check("wrap_count", 32'(count_w), 10);
    rd_addr_w = 4'd0; #1;
    check("wrap_s0_idx", 32'(rd_idx_w), 1);
    check("wrap_s0_key", 32'(rd_key_w), 1);
    rd_addr_w = 4'd1; #1;
    check("wrap_s1_idx", 32'(rd_idx_w), 0);
    check("wrap_s1_key", 32'(rd_key_w), 7);
    rd_addr_w = 4'd9; #1;
    check("wrap_s9_idx", 32'(rd_idx_w), 8);
    check("wrap_s9_key", 32'(rd_key_w), 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
